// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three FU result holding registers, age-ordered
// two-slot broadcast with registered CDB outputs and a contention counter.
module cdb_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROB_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   req_valid,
  output logic [2:0]                   req_ready,
  input  logic [2:0][5:0]              req_rd,
  input  logic [2:0][DATA_W-1:0]       req_data,
  input  logic [2:0][ROB_W-1:0]        req_rob,
  input  logic [2:0]                   req_regwrite,
  input  logic [ROB_W-1:0]             rob_head,
  input  logic                         flush,
  output logic [1:0]                   cdb_valid,
  output logic [1:0][5:0]              cdb_rd,
  output logic [1:0][DATA_W-1:0]       cdb_data,
  output logic [1:0][ROB_W-1:0]        cdb_rob,
  output logic [15:0]                  lost_cnt
);

  logic [2:0]              hold_v;
  logic [2:0][5:0]         hold_rd;
  logic [2:0][DATA_W-1:0]  hold_data;
  logic [2:0][ROB_W-1:0]   hold_rob;
  logic [2:0]              hold_rw;

  logic [2:0][ROB_W-1:0]   age;
  logic [2:0][1:0]         rank;
  logic [2:0]              grant;
  logic [2:0]              capture;
  logic                    lost;

  logic [1:0]              slot_v;
  logic [1:0][5:0]         slot_rd;
  logic [1:0][DATA_W-1:0]  slot_data;
  logic [1:0][ROB_W-1:0]   slot_rob;

  // Rank = number of held entries strictly ahead in (age, FU index) order,
  // so ranks of held entries are unique and rank directly names the slot.
  always_comb begin
    age   = '0;
    rank  = '0;
    grant = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      age[i] = hold_rob[i] - rob_head;
    end
    for (int unsigned i = 0; i < 3; i++) begin
      for (int unsigned j = 0; j < 3; j++) begin
        if (j != i && hold_v[j] &&
            ((age[j] < age[i]) || ((age[j] == age[i]) && (j < i)))) begin
          rank[i] = rank[i] + 2'd1;
        end
      end
    end
    for (int unsigned i = 0; i < 3; i++) begin
      grant[i] = hold_v[i] && (rank[i] < 2'd2);
    end
  end

  always_comb begin
    slot_v    = '0;
    slot_rd   = '0;
    slot_data = '0;
    slot_rob  = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (grant[i] && (rank[i] == 2'(s))) begin
          slot_v[s]    = 1'b1;
          slot_rd[s]   = hold_rw[i] ? hold_rd[i] : 6'd0;
          slot_data[s] = hold_data[i];
          slot_rob[s]  = hold_rob[i];
        end
      end
    end
  end

  assign lost      = |(hold_v & ~grant);
  assign req_ready = {3{rst_n & ~flush}} & (~hold_v | grant);
  assign capture   = req_valid & req_ready;

  // Capture takes precedence over grant-clear so a same-edge refill is lossless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v    <= '0;
      hold_rd   <= '0;
      hold_data <= '0;
      hold_rob  <= '0;
      hold_rw   <= '0;
    end else if (flush) begin
      hold_v <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (capture[i]) begin
          hold_v[i]    <= 1'b1;
          hold_rd[i]   <= req_rd[i];
          hold_data[i] <= req_data[i];
          hold_rob[i]  <= req_rob[i];
          hold_rw[i]   <= req_regwrite[i];
        end else if (grant[i]) begin
          hold_v[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid <= '0;
      cdb_rd    <= '0;
      cdb_data  <= '0;
      cdb_rob   <= '0;
    end else if (flush) begin
      cdb_valid <= '0;
      cdb_rd    <= '0;
      cdb_data  <= '0;
      cdb_rob   <= '0;
    end else begin
      cdb_valid <= slot_v;
      cdb_rd    <= slot_rd;
      cdb_data  <= slot_data;
      cdb_rob   <= slot_rob;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_cnt <= '0;
    end else if (!flush && lost && (lost_cnt != '1)) begin
      lost_cnt <= lost_cnt + 16'd1;
    end
  end

endmodule
